// File: rtl/maxval_host.sv
// maxval_host: PL-side self-test host for the maxval accelerator.
// Fills BRAM port A, runs the go/done handshake, checks word 0.
module maxval_host #(
  parameter int          NWORDS         = 2048,
  parameter int          ADDR_W         = 13,
  parameter logic [31:0] SEED           = 32'h0000_0001,
  parameter bit          FORCE_LAST_MAX = 1'b0,
  parameter int          TIMEOUT        = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [31:0]       ps_control,
  input  logic [31:0]       pl_status,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_wrdata,
  input  logic [31:0]       bram_rddata,
  output logic [3:0]        bram_we,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout_err,
  output logic [31:0]       expected_max,
  output logic [31:0]       result
);

  localparam logic [31:0] TAPS = 32'h8020_0003;
  localparam logic [31:0] SEED_EFF =
    (SEED == 32'h0) ? 32'h1 : SEED;
  localparam int IDX_W =
    (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NWORDS - 1);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_GO,
    S_ACK,
    S_RD_ADDR,
    S_RD_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state, next_state;
  logic [IDX_W-1:0] idx;
  logic [31:0]      lfsr;
  logic [31:0]      wait_cnt;
  logic [31:0]      wr_val;
  logic             accept;
  logic             tmo;
  logic             timed_out;
  logic             unused_status;

  assign unused_status = ^pl_status[31:1];
  assign timed_out = (wait_cnt == TO_LAST);
  assign wr_val = (FORCE_LAST_MAX && idx == LAST)
                ? 32'hFFFF_FFFF : lfsr;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    ps_control  = '0;
    bram_addr   = '0;
    bram_wrdata = '0;
    bram_we     = '0;
    busy        = 1'b1;
    done        = 1'b0;
    accept      = 1'b0;
    tmo         = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          accept     = 1'b1;
          next_state = S_FILL;
        end
      end
      S_FILL: begin
        bram_we     = 4'hF;
        bram_addr   = ADDR_W'({idx, 2'b00});
        bram_wrdata = wr_val;
        if (idx == LAST) next_state = S_GO;
      end
      S_GO: begin
        ps_control = 32'd1;
        if (pl_status[0]) begin
          next_state = S_ACK;
        end else if (timed_out) begin
          tmo        = 1'b1;
          next_state = S_DONE;
        end
      end
      S_ACK: begin
        if (!pl_status[0]) begin
          next_state = S_RD_ADDR;
        end else if (timed_out) begin
          tmo        = 1'b1;
          next_state = S_DONE;
        end
      end
      S_RD_ADDR: next_state = S_RD_WAIT;
      S_RD_WAIT: next_state = S_CHECK;
      S_CHECK:   next_state = S_DONE;
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          next_state = S_FILL;
        end
      end
    endcase
  end

  // wait_cnt restarts whenever the state changes
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx          <= '0;
      lfsr         <= '0;
      wait_cnt     <= '0;
      expected_max <= '0;
      result       <= '0;
      pass         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (next_state != state) wait_cnt <= '0;
      else                     wait_cnt <= wait_cnt + 32'd1;
      if (accept) begin
        idx          <= '0;
        lfsr         <= SEED_EFF;
        expected_max <= '0;
        result       <= '0;
        pass         <= 1'b0;
        timeout_err  <= 1'b0;
      end
      if (state == S_FILL) begin
        idx  <= idx + IDX_W'(1);
        lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);
        if (wr_val > expected_max) expected_max <= wr_val;
      end
      if (tmo) begin
        timeout_err <= 1'b1;
        pass        <= 1'b0;
      end
      if (state == S_RD_WAIT) result <= bram_rddata;
      if (state == S_CHECK)   pass   <= (result == expected_max);
    end
  end

endmodule

// File: tb/tb_maxval_host.sv
// tb_maxval_host: two hosts (seed-0 / forced-last-max) on BRAM +
// behavioural maxval models, scoreboarded against a reference fill.
module tb_maxval_host;

  localparam int N  = 16;
  localparam int AW = 13;
  localparam int TO = 100;
  localparam logic [31:0] SEED1 = 32'hC0FF_EE11;
  localparam logic [31:0] TAPS  = 32'h8020_0003;

  typedef struct {
    int          k;
    logic [31:0] res;
    logic [31:0] mx;
    logic        ps;
    logic        to;
  } exp_t;

  typedef struct {
    int          k;
    int          i;
    logic [31:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start [2];
  logic [31:0]   ps_control [2];
  logic [31:0]   pl_status [2];
  logic [AW-1:0] addr [2];
  logic [31:0]   wrdata [2];
  logic [31:0]   rddata [2];
  logic [3:0]    we [2];
  logic          busy [2];
  logic          done [2];
  logic          pass [2];
  logic          tmo [2];
  logic [31:0]   expmax [2];
  logic [31:0]   result [2];

  logic [31:0]   mem [2][N];
  int            mode [2];
  int            mst [2];
  int            mdly [2];

  exp_t sq[$];
  wr_t  wq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    maxval_host #(
      .NWORDS(N), .ADDR_W(AW),
      .SEED(g == 0 ? 32'h0 : SEED1),
      .FORCE_LAST_MAX(g == 1),
      .TIMEOUT(TO)
    ) u_dut (
      .clk(clk), .reset(reset), .start(start[g]),
      .ps_control(ps_control[g]), .pl_status(pl_status[g]),
      .bram_addr(addr[g]), .bram_wrdata(wrdata[g]),
      .bram_rddata(rddata[g]), .bram_we(we[g]),
      .busy(busy[g]), .done(done[g]), .pass(pass[g]),
      .timeout_err(tmo[g]), .expected_max(expmax[g]),
      .result(result[g])
    );
  end

  // BRAM port A plus a maxval model on port B
  // mode: 0 correct, 1 writes 0x12345678, 2 never answers
  always @(posedge clk) begin
    logic [31:0] mx;
    for (int k = 0; k < 2; k++) begin
      if (we[k] == 4'hF) mem[k][addr[k][5:2]] <= wrdata[k];
      rddata[k] <= mem[k][addr[k][5:2]];
      if (!reset) begin
        mst[k] <= 0;
        pl_status[k] <= 32'h0;
      end else begin
        case (mst[k])
          0: if (ps_control[k][0] && mode[k] != 2) begin
               mst[k]  <= 1;
               mdly[k] <= int'($urandom_range(1, 6));
             end
          1: if (mdly[k] > 0) mdly[k] <= mdly[k] - 1;
             else begin
               mx = 32'h0;
               for (int j = 0; j < N; j++)
                 if (mem[k][j] > mx) mx = mem[k][j];
               mem[k][0] <= (mode[k] == 1) ? 32'h1234_5678 : mx;
               pl_status[k] <= 32'h1;
               mst[k] <= 2;
             end
          2: if (!ps_control[k][0]) begin
               mst[k]  <= 3;
               mdly[k] <= int'($urandom_range(0, 5));
             end
          default:
             if (mdly[k] > 0) mdly[k] <= mdly[k] - 1;
             else begin
               pl_status[k] <= 32'h0;
               mst[k] <= 0;
             end
        endcase
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endtask

  // reference fill sequence: Galois LFSR, word i = state before i-th step
  task automatic ref_fill(input int k, output logic [31:0] mx);
    logic [31:0] s, v;
    wr_t w;
    s  = (k == 0) ? 32'h0 : SEED1;
    if (s == 32'h0) s = 32'h1;
    mx = 32'h0;
    for (int i = 0; i < N; i++) begin
      v = (k == 1 && i == N - 1) ? 32'hFFFF_FFFF : s;
      w.k = k; w.i = i; w.d = v;
      wq.push_back(w);
      if (v > mx) mx = v;
      s = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // monitor: pops expected writes and results as the DUTs present them
  initial begin
    logic pd [2];
    exp_t e;
    wr_t  w;
    pd = '{1'b0, 1'b0};
    forever begin
      step();
      for (int k = 0; k < 2; k++) begin
        if (we[k] != 4'h0) begin
          if (wq.size() == 0) chk("unexpected write", 32'(we[k]), 0);
          else begin
            w = wq.pop_front();
            chk("wr inst", k, w.k);
            chk("wr we", 32'(we[k]), 32'hF);
            chk("wr addr", 32'(addr[k]), w.i * 4);
            chk("wr data", wrdata[k], w.d);
          end
        end
        if (done[k] && !pd[k]) begin
          if (sq.size() == 0) chk("unexpected done", 32'(done[k]), 0);
          else begin
            e = sq.pop_front();
            chk("done inst", k, e.k);
            chk("result", result[k], e.res);
            chk("expected_max", expmax[k], e.mx);
            chk("pass", 32'(pass[k]), 32'(e.ps));
            chk("timeout_err", 32'(tmo[k]), 32'(e.to));
            chk("ps_control at done", ps_control[k], 0);
            chk("busy at done", 32'(busy[k]), 0);
          end
        end
        pd[k] = done[k];
      end
    end
  end

  task automatic run(input int k, input int md, input int mid);
    logic [31:0] mx;
    exp_t e;
    int n;
    mode[k] = md;
    ref_fill(k, mx);
    e.k   = k;
    e.mx  = mx;
    e.to  = (md == 2);
    e.ps  = (md == 0);
    e.res = (md == 0) ? mx : (md == 1) ? 32'h1234_5678 : 32'h0;
    sq.push_back(e);
    step();
    start[k] = 1'b1;
    n = 0;
    while (!ps_control[k][0] && n < 200) begin
      step();
      n++;
      start[k] = (mid != 0 && n == mid);
      if (n == 1) begin
        chk("busy after start", 32'(busy[k]), 1);
        chk("done after start", 32'(done[k]), 0);
      end
    end
    start[k] = 1'b0;
    chk("start to go latency", n, N + 1);
    if (md == 2) begin
      n = 0;
      while (ps_control[k][0] && n < 500) begin step(); n++; end
      chk("cycles in GO", n, TO);
    end else begin
      n = 0;
      while (!pl_status[k][0] && n < 200) begin step(); n++; end
      n = 0;
      while (pl_status[k][0] && n < 200) begin step(); n++; end
      n = 0;
      while (!done[k] && n < 50) begin step(); n++; end
      chk("status fall to done", n, 4);
    end
    n = 0;
    while (!done[k] && n < 50) begin step(); n++; end
    chk("done reached", 32'(done[k]), 1);
  endtask

  task automatic reset_in_go();
    logic [31:0] mx;
    int n;
    mode[1] = 0;
    ref_fill(1, mx);
    step();
    start[1] = 1'b1;
    n = 0;
    while (!ps_control[1][0] && n < 200) begin
      step();
      n++;
      start[1] = 1'b0;
    end
    reset    = 1'b0;
    start[1] = 1'b1;
    step();
    chk("rst ps_control", ps_control[1], 0);
    chk("rst busy", 32'(busy[1]), 0);
    chk("rst done", 32'(done[1]), 0);
    chk("rst we", 32'(we[1]), 0);
    chk("rst expected_max", expmax[1], 0);
    chk("rst other done", 32'(done[0]), 0);
    reset    = 1'b1;
    start[1] = 1'b0;
  endtask

  initial begin
    reset  = 1'b0;
    start  = '{1'b0, 1'b0};
    mode   = '{0, 0};
    repeat (3) step();
    for (int k = 0; k < 2; k++) begin
      chk("reset ps_control", ps_control[k], 0);
      chk("reset we", 32'(we[k]), 0);
      chk("reset addr", 32'(addr[k]), 0);
      chk("reset wrdata", wrdata[k], 0);
      chk("reset busy", 32'(busy[k]), 0);
      chk("reset done", 32'(done[k]), 0);
      chk("reset pass", 32'(pass[k]), 0);
      chk("reset timeout", 32'(tmo[k]), 0);
      chk("reset expected_max", expmax[k], 0);
      chk("reset result", result[k], 0);
    end
    reset = 1'b1;
    run(1, 0, 0);
    run(1, 1, 0);
    run(1, 2, 0);
    run(0, 0, 0);
    for (int r = 0; r < 3; r++)
      run(0, 0, int'($urandom_range(2, N - 2)));
    reset_in_go();
    run(1, 0, 0);
    repeat (3) step();
    chk("write queue drained", wq.size(), 0);
    chk("result queue drained", sq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
